// File: rtl/poly_lowval_pkg.sv
// Shared constants for the ALU1 polynomial scanners (valuation and degree finders).
package poly_lowval_pkg;

    localparam int unsigned COEF_W = 16;
    localparam int unsigned N_COEF = 9;
    localparam int unsigned M      = N_COEF * COEF_W;
    localparam int unsigned DEG_W  = 4;

    // Scanner FSM encodings, common to both finders
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] SCAN = 1'b1;

endpackage

// File: rtl/poly_lowval.sv
// x-adic valuation finder: strips zero low-order coefficients one per cycle and
// reports the shift count together with the normalized quotient T(x)/x^v.
module poly_lowval
    import poly_lowval_pkg::*;
(
    input  logic             clk,
    input  logic             rst_b,
    input  logic             start,
    input  logic [0:M-1]     poly_in,
    output logic [0:M-1]     poly_out,
    output logic [DEG_W-1:0] val_out,
    output logic             zero_poly,
    output logic             busy,
    output logic             val_done
);

    localparam logic [DEG_W-1:0] CNT_LAST = DEG_W'(N_COEF - 1);

    logic [0:0]       state;
    logic [0:0]       state_nxt;
    logic [0:M-1]     shift_reg;
    logic [DEG_W-1:0] cnt;

    logic             low_zero_c;
    logic             load_c;
    logic             shift_c;
    logic             finish_c;

    // Slot-zero test: the x^0 coefficient currently at the head of the shifter
    assign low_zero_c = (shift_reg[0:COEF_W-1] == '0);

    // State register
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and step decode
    always_comb begin
        state_nxt = state;
        load_c    = 1'b0;
        shift_c   = 1'b0;
        finish_c  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load_c    = 1'b1;
                    state_nxt = SCAN;
                end
            end
            SCAN: begin
                if (low_zero_c && (cnt != CNT_LAST)) begin
                    shift_c = 1'b1;
                end else begin
                    finish_c  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Shifter and step counter
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            shift_reg <= '0;
            cnt       <= '0;
        end else if (load_c) begin
            shift_reg <= poly_in;
            cnt       <= '0;
        end else if (shift_c) begin
            shift_reg <= {shift_reg[COEF_W:M-1], COEF_W'(0)};
            cnt       <= cnt + DEG_W'(1);
        end
    end

    // Result registers; hold the last result until the next completion
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            poly_out  <= '0;
            val_out   <= '0;
            zero_poly <= 1'b0;
            busy      <= 1'b0;
            val_done  <= 1'b0;
        end else begin
            val_done <= 1'b0;
            if (load_c) begin
                busy <= 1'b1;
            end
            if (finish_c) begin
                poly_out  <= shift_reg;
                val_out   <= cnt;
                zero_poly <= low_zero_c;
                val_done  <= 1'b1;
                busy      <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_poly_lowval.sv
// Self-checking bench for poly_lowval: directed table, randomized vectors against a
// coefficient-array model, and hand sequences for restart, back-to-back and reset abort.
module tb_poly_lowval;
    import poly_lowval_pkg::*;

    logic             clk;
    logic             rst_b;
    logic             start;
    logic [0:M-1]     poly_in;
    logic [0:M-1]     poly_out;
    logic [DEG_W-1:0] val_out;
    logic             zero_poly;
    logic             busy;
    logic             val_done;

    int n_vec;
    int n_err;

    typedef struct {
        logic [0:M-1] poly;
        logic [0:M-1] exp_out;
        logic [3:0]   exp_val;
        logic         exp_zero;
    } vec_t;

    vec_t vecs[$];

    poly_lowval dut (
        .clk       (clk),
        .rst_b     (rst_b),
        .start     (start),
        .poly_in   (poly_in),
        .poly_out  (poly_out),
        .val_out   (val_out),
        .zero_poly (zero_poly),
        .busy      (busy),
        .val_done  (val_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [M-1:0] act, input logic [M-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [0:M-1] put(input logic [0:M-1] p, input int i, input logic [15:0] c);
        logic [0:M-1] r;
        r = p;
        r[COEF_W*i +: COEF_W] = c;
        return r;
    endfunction

    // Reference: unpack into coefficients, find lowest nonzero index, re-index.
    task automatic model(input logic [0:M-1] p, output logic [0:M-1] q,
                         output logic [3:0] v, output logic z);
        logic [15:0] c [N_COEF];
        int lo;
        for (int i = 0; i < N_COEF; i++) c[i] = p[COEF_W*i +: COEF_W];
        lo = -1;
        for (int i = N_COEF - 1; i >= 0; i--) if (c[i] != 16'h0) lo = i;
        q = '0;
        if (lo < 0) begin
            v = 4'd8;
            z = 1'b1;
        end else begin
            v = 4'(lo);
            z = 1'b0;
            for (int i = 0; i + lo < N_COEF; i++) q = put(q, i, c[i+lo]);
        end
    endtask

    // Launch one scan and wait (bounded) for completion; lat = edges after E0.
    task automatic do_scan(input logic [0:M-1] p, input string tag, output int lat);
        @(negedge clk);
        poly_in = p;
        start   = 1'b1;
        @(posedge clk);
        #1;
        start   = 1'b0;
        poly_in = ~p;
        check({tag, " busy_after_start"}, M'(busy), M'(1));
        lat = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            #1;
            lat++;
            if (val_done) break;
        end
        if (!val_done) begin
            n_vec++;
            n_err++;
            $display("FAIL %s timeout: val_done not seen in 20 edges", tag);
        end
    endtask

    task automatic check_result(input string tag, input vec_t v, input int lat);
        check({tag, " poly_out"},  poly_out,       v.exp_out);
        check({tag, " val_out"},   M'(val_out),    M'(v.exp_val));
        check({tag, " zero_poly"}, M'(zero_poly),  M'(v.exp_zero));
        check({tag, " latency"},   M'(lat),        M'(v.exp_val + 4'd1));
        check({tag, " busy_done"}, M'(busy),       M'(0));
    endtask

    initial begin
        vec_t v;
        vec_t t1, t2, t3;
        int lat;
        int seen;
        logic [0:M-1] p;
        logic [0:M-1] q;
        logic [3:0] vv;
        logic z;

        n_vec   = 0;
        n_err   = 0;
        rst_b   = 1'b0;
        start   = 1'b0;
        poly_in = '0;

        // Directed table entries (expected values written out by hand)
        t1.poly = put('0, 0, 16'h0001);
        t1.exp_out = t1.poly; t1.exp_val = 4'd0; t1.exp_zero = 1'b0;
        t2.poly = put(put('0, 3, 16'hBEEF), 5, 16'h0001);
        t2.exp_out = put(put('0, 0, 16'hBEEF), 2, 16'h0001); t2.exp_val = 4'd3; t2.exp_zero = 1'b0;
        t3.poly = put('0, 8, 16'h8000);
        t3.exp_out = put('0, 0, 16'h8000); t3.exp_val = 4'd8; t3.exp_zero = 1'b0;
        vecs.push_back(t1);
        vecs.push_back(t2);
        vecs.push_back(t3);
        v.poly = '0; v.exp_out = '0; v.exp_val = 4'd8; v.exp_zero = 1'b1;
        vecs.push_back(v);

        // Randomized entries, expectations from the model
        for (int n = 0; n < 24; n++) begin
            int lo;
            lo = (n == 5) ? 9 : int'($urandom_range(0, 8));
            p = '0;
            for (int i = 0; i < N_COEF; i++) begin
                logic [15:0] c;
                c = 16'($urandom);
                if (i < lo) c = 16'h0;
                else if (i == lo && c == 16'h0) c = 16'h0100;
                else if (i > lo && $urandom_range(0, 3) == 0) c = 16'h0;
                p = put(p, i, c);
            end
            model(p, q, vv, z);
            v.poly = p; v.exp_out = q; v.exp_val = vv; v.exp_zero = z;
            vecs.push_back(v);
        end

        // Reset state
        #12;
        check("rst poly_out",  poly_out,        '0);
        check("rst val_out",   M'(val_out),     M'(0));
        check("rst zero_poly", M'(zero_poly),   M'(0));
        check("rst busy",      M'(busy),        M'(0));
        check("rst val_done",  M'(val_done),    M'(0));
        @(negedge clk);
        rst_b = 1'b1;

        // Table sweep
        foreach (vecs[i]) begin
            do_scan(vecs[i].poly, $sformatf("vec%0d", i), lat);
            check_result($sformatf("vec%0d", i), vecs[i], lat);
            @(posedge clk);
            #1;
            check($sformatf("vec%0d done_pulse_1cyc", i), M'(val_done), M'(0));
            check($sformatf("vec%0d hold", i), poly_out, vecs[i].exp_out);
        end

        // Restart attempt and poly_in change mid-scan are ignored
        @(negedge clk);
        poly_in = t2.poly;
        start   = 1'b1;
        @(posedge clk);
        #1;
        start   = 1'b0;
        poly_in = t1.poly;
        lat = 0;
        for (int k = 0; k < 20; k++) begin
            if (k == 1) begin
                start   = 1'b1;
                poly_in = put('0, 0, 16'h1234);
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
            lat++;
            if (val_done) break;
        end
        start = 1'b0;
        check_result("restart_ignored", t2, lat);

        // Back-to-back: start in the val_done cycle launches T1
        poly_in = t1.poly;
        start   = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("b2b busy",       M'(busy),     M'(1));
        check("b2b done_low",   M'(val_done), M'(0));
        check("b2b hold_prev",  poly_out,     t2.exp_out);
        check("b2b hold_val",   M'(val_out),  M'(3));
        @(posedge clk);
        #1;
        check("b2b done",       M'(val_done), M'(1));
        check_result("b2b", t1, 1);

        // Reset abort during step 3 of T3
        do_scan(t2.poly, "pre_abort", lat);
        @(negedge clk);
        poly_in = t3.poly;
        start   = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_b = 1'b0;
        #1;
        check("abort poly_out",  poly_out,      '0);
        check("abort val_out",   M'(val_out),   M'(0));
        check("abort zero_poly", M'(zero_poly), M'(0));
        check("abort busy",      M'(busy),      M'(0));
        seen = 0;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (val_done) seen++;
        end
        @(negedge clk);
        rst_b = 1'b1;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (val_done) seen++;
        end
        check("abort no_done", M'(seen), M'(0));
        do_scan(t1.poly, "post_abort", lat);
        check_result("post_abort", t1, lat);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
